// File: rtl/slow_clock_monitor.sv
// ---------------------------------------------------------------------------
// slow_clock_monitor
//
// Fast-domain monitor for a slow toggling clock (normally a divider output).
// The slow level is synchronised into the clkin domain. Every synchronised
// level change produces a one-cycle rise_tick or fall_tick, so downstream
// logic can stay on clkin and use enables instead of a derived clock. The
// block also measures the half-period in clkin cycles and, optionally,
// flags a slow clock that has stopped toggling.
//
// Parameters
//   SYNC_STAGES  synchroniser depth, must be at least 2
//   CNT_W        width of the edge-interval counter and of half_period
//   TIMEOUT      clkin cycles without an edge before stall is declared,
//                must satisfy 1 <= TIMEOUT < 2**CNT_W - 1
//
// Ports
//   clkin         in   fast system clock, all logic on its rising edge
//   reset         in   asynchronous, active-high reset
//   slowin        in   slow toggling input, asynchronous to clkin
//   rise_tick     out  one-cycle pulse per synchronised rising edge
//   fall_tick     out  one-cycle pulse per synchronised falling edge
//   half_period   out  clkin cycles between the last two edges
//   period_valid  out  half_period holds a real measurement
//   stalled       out  no edge seen for TIMEOUT cycles
//
// Build option
//   SLOW_MON_STALL_EN  when defined, the timeout comparison, the STALLED
//                      state and the stalled output are built. When not
//                      defined, stalled is tied low, period_valid only
//                      drops on reset and TIMEOUT has no functional effect.
// ---------------------------------------------------------------------------
module slow_clock_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 25,
  parameter int TIMEOUT     = 1000
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             slowin,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             stalled
);

  // Measurement progress. The first edge after reset (or after a stall)
  // only gives a reference point; the second one yields a real interval.
  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    LOCKED     = 2'd2
`ifdef SLOW_MON_STALL_EN
    , STALLED  = 2'd3
`endif
  } mon_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Parameter sanity: a single flop is not a synchroniser, and a timeout
  // at or beyond the saturation value could never be matched reliably.
  if (SYNC_STAGES < 2) begin : g_check_sync
    $error("slow_clock_monitor: SYNC_STAGES must be at least 2");
  end
  if ((TIMEOUT < 1) ||
      (longint'(TIMEOUT) >= ((longint'(1) << CNT_W) - longint'(1)))) begin : g_check_timeout
    $error("slow_clock_monitor: TIMEOUT must be in 1 .. 2**CNT_W-2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_level;
  logic                   prev;
  logic                   edge_det;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  mon_state_t             state_q;
  mon_state_t             state_d;
  logic [CNT_W-1:0]       half_d;
  logic                   valid_d;

  // Synchroniser chain. slowin enters at bit 0 and the settled level is
  // taken from the top bit.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slowin};
    end
  end

  assign sync_level = sync_q[SYNC_STAGES-1];
  assign edge_det   = (sync_level != prev);

  // prev trails the synchronised level by one cycle; any difference is an
  // edge. The ticks are registered so they line up with the state and
  // half_period updates made on the same clock edge.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      prev      <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      prev      <= sync_level;
      rise_tick <= edge_det & sync_level;
      fall_tick <= edge_det & ~sync_level;
    end
  end

  // Saturating increment. It serves both as the next counter value and as
  // the captured interval: the counter restarts at 0 on the edge cycle, so
  // the cycle count between edges is cnt + 1.
  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);

  // Interval counter: cleared on every edge, otherwise counts up and
  // sticks at all-ones so a long gap never wraps into a short reading.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (edge_det) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end

`ifdef SLOW_MON_STALL_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  logic timeout_hit;
  logic stalled_d;

  // An edge in the same cycle as the timeout match resets the interval,
  // so the edge wins and no stall is declared.
  assign timeout_hit = !edge_det && (cnt == TIMEOUT_LAST);
`endif

  // Next-state and next-output logic for the measurement FSM.
  always_comb begin
    state_d = state_q;
    half_d  = half_period;
    valid_d = period_valid;
`ifdef SLOW_MON_STALL_EN
    stalled_d = stalled;
`endif

    case (state_q)
      WAIT_FIRST: begin
        if (edge_det) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          state_d = LOCKED;
          half_d  = cnt_inc;
          valid_d = 1'b1;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          half_d = cnt_inc;
        end
      end
`ifdef SLOW_MON_STALL_EN
      STALLED: begin
        // The interval ending here spans the stall and is meaningless,
        // so measurement restarts without touching half_period.
        if (edge_det) begin
          state_d   = MEASURE;
          stalled_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = WAIT_FIRST;
      end
    endcase

`ifdef SLOW_MON_STALL_EN
    if (timeout_hit) begin
      state_d   = STALLED;
      stalled_d = 1'b1;
      valid_d   = 1'b0;
    end
`endif
  end

  // FSM state and the registered measurement outputs.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_FIRST;
      half_period  <= '0;
      period_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_period  <= half_d;
      period_valid <= valid_d;
    end
  end

`ifdef SLOW_MON_STALL_EN
  // Stall flag, raised on the cycle the timeout is reached and cleared by
  // the next edge.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      stalled <= 1'b0;
    end else begin
      stalled <= stalled_d;
    end
  end
`else
  assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_slow_clock_monitor.sv
// ---------------------------------------------------------------------------
// tb_slow_clock_monitor
//
// Directed bench for slow_clock_monitor. Inputs change on the falling edge
// of clkin and outputs are sampled on the falling edge, half a cycle away
// from the active rising edge. A slowin change made at a falling edge is
// captured at the next rising edge k, and its tick is visible at the
// falling edge following rising edge k+2, i.e. three falling edges later.
// With SLOW_MON_STALL_EN defined the stall scenarios run at CNT_W = 25,
// TIMEOUT = 1000; otherwise CNT_W = 8 to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_slow_clock_monitor;

  localparam int SYNC_STAGES = 2;
`ifdef SLOW_MON_STALL_EN
  localparam int CNT_W   = 25;
  localparam int TIMEOUT = 1000;
`else
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;
`endif

  logic             clkin = 1'b0;
  logic             reset;
  logic             slowin;
  logic             rise_tick;
  logic             fall_tick;
  logic [CNT_W-1:0] half_period;
  logic             period_valid;
  logic             stalled;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  slow_clock_monitor #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .slowin       (slowin),
    .rise_tick    (rise_tick),
    .fall_tick    (fall_tick),
    .half_period  (half_period),
    .period_valid (period_valid),
    .stalled      (stalled)
  );

  // 10 ns clock and a count of rising edges for absolute-cycle stimulus.
  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  // Advance n falling edges.
  task automatic step(input int n);
    repeat (n) @(negedge clkin);
  endtask

  // Synchronous-looking reset pulse, leaving the bench at a falling edge.
  task automatic do_reset();
    @(negedge clkin);
    reset  = 1'b1;
    slowin = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // Reset values, including slowin activity while reset is held.
  task automatic test_reset();
    reset  = 1'b1;
    slowin = 1'b1;
    step(3);
    n_checks++; if (rise_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rise: got %0b want 0", rise_tick); end
    n_checks++; if (fall_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_fall: got %0b want 0", fall_tick); end
    n_checks++; if (half_period !== CNT_W'(0)) begin n_fail++; $display("[TB] FAIL rst_half: got %0d want 0", half_period); end
    n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %0b want 0", period_valid); end
    n_checks++; if (stalled !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_stalled: got %0b want 0", stalled); end
    slowin = 1'b0;
    reset  = 1'b0;
    step(4);
    n_checks++; if (rise_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_after_rise: got %0b want 0", rise_tick); end
    n_checks++; if (fall_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_after_fall: got %0b want 0", fall_tick); end
    n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_after_valid: got %0b want 0", period_valid); end
  endtask

  // slowin 0->1 captured at rising edge 100: rise_tick high only in the
  // cycle after rising edge 102.
  task automatic test_latency();
    while (cyc < 99) @(negedge clkin);
    slowin = 1'b1;
    step(1);
    n_checks++; if (rise_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL lat_c100: cyc=%0d rise_tick got %0b want 0", cyc, rise_tick); end
    step(1);
    n_checks++; if (rise_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL lat_c101: cyc=%0d rise_tick got %0b want 0", cyc, rise_tick); end
    step(1);
    n_checks++; if (rise_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL lat_c102: cyc=%0d rise_tick got %0b want 1", cyc, rise_tick); end
    n_checks++; if (fall_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL lat_c102_fall: cyc=%0d fall_tick got %0b want 0", cyc, fall_tick); end
    step(1);
    n_checks++; if (rise_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL lat_c103: cyc=%0d rise_tick got %0b want 0", cyc, rise_tick); end
  endtask

  // Divider with reload 10 (toggle every 11 cycles), then a 7-cycle gap,
  // then two back-to-back toggles for the minimum half-period.
  task automatic test_toggle();
    do_reset();
    slowin = 1'b1;
    step(3);
    n_checks++; if (rise_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL tog_e0_rise: got %0b want 1", rise_tick); end
    n_checks++; if (fall_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL tog_e0_fall: got %0b want 0", fall_tick); end
    n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL tog_e0_valid: got %0b want 0", period_valid); end
    step(8);
    slowin = 1'b0;
    step(3);
    n_checks++; if (fall_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL tog_e1_fall: got %0b want 1", fall_tick); end
    n_checks++; if (rise_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL tog_e1_rise: got %0b want 0", rise_tick); end
    n_checks++; if (half_period !== CNT_W'(11)) begin n_fail++; $display("[TB] FAIL tog_e1_half: got %0d want 11", half_period); end
    n_checks++; if (period_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL tog_e1_valid: got %0b want 1", period_valid); end
    step(1);
    n_checks++; if (fall_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL tog_e1_width: fall_tick got %0b want 0", fall_tick); end
    step(7);
    slowin = 1'b1;
    step(3);
    n_checks++; if (rise_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL tog_e2_rise: got %0b want 1", rise_tick); end
    n_checks++; if (half_period !== CNT_W'(11)) begin n_fail++; $display("[TB] FAIL tog_e2_half: got %0d want 11", half_period); end
    step(4);
    slowin = 1'b0;
    step(3);
    n_checks++; if (fall_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL tog_e3_fall: got %0b want 1", fall_tick); end
    n_checks++; if (half_period !== CNT_W'(7)) begin n_fail++; $display("[TB] FAIL tog_e3_half: got %0d want 7", half_period); end
    slowin = 1'b1;
    step(1);
    slowin = 1'b0;
    step(2);
    n_checks++; if (rise_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL tog_e4_rise: got %0b want 1", rise_tick); end
    n_checks++; if (half_period !== CNT_W'(3)) begin n_fail++; $display("[TB] FAIL tog_e4_half: got %0d want 3", half_period); end
    step(1);
    n_checks++; if (fall_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL tog_e5_fall: got %0b want 1", fall_tick); end
    n_checks++; if (rise_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL tog_e5_rise: got %0b want 0", rise_tick); end
    n_checks++; if (half_period !== CNT_W'(1)) begin n_fail++; $display("[TB] FAIL tog_e5_half: got %0d want 1", half_period); end
  endtask

  // Reset asserted between clock edges while locked and while a tick is
  // high; afterwards two edges are needed before period_valid returns.
  task automatic test_reset_mid();
    do_reset();
    slowin = 1'b1;
    step(11);
    slowin = 1'b0;
    step(11);
    slowin = 1'b1;
    step(3);
    n_checks++; if (rise_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_pre_rise: got %0b want 1", rise_tick); end
    n_checks++; if (half_period !== CNT_W'(11)) begin n_fail++; $display("[TB] FAIL mid_pre_half: got %0d want 11", half_period); end
    n_checks++; if (period_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_pre_valid: got %0b want 1", period_valid); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (rise_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_async_rise: got %0b want 0", rise_tick); end
    n_checks++; if (fall_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_async_fall: got %0b want 0", fall_tick); end
    n_checks++; if (half_period !== CNT_W'(0)) begin n_fail++; $display("[TB] FAIL mid_async_half: got %0d want 0", half_period); end
    n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_async_valid: got %0b want 0", period_valid); end
    n_checks++; if (stalled !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_async_stalled: got %0b want 0", stalled); end
    step(2);
    reset = 1'b0;
    step(3);
    n_checks++; if (rise_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_e0_rise: got %0b want 1", rise_tick); end
    n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_e0_valid: got %0b want 0", period_valid); end
    n_checks++; if (half_period !== CNT_W'(0)) begin n_fail++; $display("[TB] FAIL mid_e0_half: got %0d want 0", half_period); end
    step(8);
    slowin = 1'b0;
    step(2);
    n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_e1_early_valid: got %0b want 0", period_valid); end
    step(1);
    n_checks++; if (fall_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_e1_fall: got %0b want 1", fall_tick); end
    n_checks++; if (period_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_e1_valid: got %0b want 1", period_valid); end
    n_checks++; if (half_period !== CNT_W'(11)) begin n_fail++; $display("[TB] FAIL mid_e1_half: got %0d want 11", half_period); end
  endtask

`ifdef SLOW_MON_STALL_EN
  // Lock, then hold slowin: stalled rises exactly TIMEOUT cycles after the
  // last tick; the next edge clears it without a half_period update.
  task automatic test_stall();
    do_reset();
    slowin = 1'b1;
    step(11);
    slowin = 1'b0;
    step(3);
    n_checks++; if (period_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_lock_valid: got %0b want 1", period_valid); end
    step(999);
    n_checks++; if (stalled !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_999: got %0b want 0", stalled); end
    n_checks++; if (period_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_999_valid: got %0b want 1", period_valid); end
    step(1);
    n_checks++; if (stalled !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_1000: got %0b want 1", stalled); end
    n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_1000_valid: got %0b want 0", period_valid); end
    step(5);
    slowin = 1'b1;
    step(3);
    n_checks++; if (rise_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_resume_rise: got %0b want 1", rise_tick); end
    n_checks++; if (stalled !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_resume_stalled: got %0b want 0", stalled); end
    n_checks++; if (half_period !== CNT_W'(11)) begin n_fail++; $display("[TB] FAIL stall_resume_half: got %0d want 11", half_period); end
    n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_resume_valid: got %0b want 0", period_valid); end
    step(6);
    slowin = 1'b0;
    step(3);
    n_checks++; if (period_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_relock_valid: got %0b want 1", period_valid); end
    n_checks++; if (half_period !== CNT_W'(9)) begin n_fail++; $display("[TB] FAIL stall_relock_half: got %0d want 9", half_period); end
  endtask

  // Edge arriving on the cycle the counter reads TIMEOUT-1: edge wins.
  task automatic test_coincident();
    do_reset();
    slowin = 1'b1;
    step(11);
    slowin = 1'b0;
    step(3);
    step(997);
    slowin = 1'b1;
    step(2);
    n_checks++; if (stalled !== 1'b0) begin n_fail++; $display("[TB] FAIL coin_999_stalled: got %0b want 0", stalled); end
    step(1);
    n_checks++; if (rise_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL coin_rise: got %0b want 1", rise_tick); end
    n_checks++; if (stalled !== 1'b0) begin n_fail++; $display("[TB] FAIL coin_stalled: got %0b want 0", stalled); end
    n_checks++; if (half_period !== CNT_W'(1000)) begin n_fail++; $display("[TB] FAIL coin_half: got %0d want 1000", half_period); end
    n_checks++; if (period_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL coin_valid: got %0b want 1", period_valid); end
  endtask
`else
  // Without the stall logic a long hold never stalls; the counter sticks at
  // 255 so both a 300-cycle and a 256-cycle gap report 255.
  task automatic test_saturate();
    do_reset();
    slowin = 1'b1;
    step(11);
    slowin = 1'b0;
    step(300);
    n_checks++; if (stalled !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_hold_stalled: got %0b want 0", stalled); end
    n_checks++; if (period_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_hold_valid: got %0b want 1", period_valid); end
    slowin = 1'b1;
    step(3);
    n_checks++; if (rise_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_rise: got %0b want 1", rise_tick); end
    n_checks++; if (half_period !== CNT_W'(255)) begin n_fail++; $display("[TB] FAIL sat_half_300: got %0d want 255", half_period); end
    step(253);
    slowin = 1'b0;
    step(3);
    n_checks++; if (half_period !== CNT_W'(255)) begin n_fail++; $display("[TB] FAIL sat_half_256: got %0d want 255", half_period); end
    n_checks++; if (stalled !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_end_stalled: got %0b want 0", stalled); end
  endtask
`endif

  initial begin
    reset  = 1'b1;
    slowin = 1'b0;
    test_reset();
    test_latency();
    test_toggle();
    test_reset_mid();
`ifdef SLOW_MON_STALL_EN
    test_stall();
    test_coincident();
`else
    test_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/slow_clock_monitor.md
# slow_clock_monitor

Fast-domain monitor for the divided slow clock. Synchronises a slow toggling input (normally the divider output) into the `clkin` domain and emits one-cycle rise/fall enable pulses, so downstream logic can run on `clkin` with enables instead of on a derived clock. Also reports the measured half-period in `clkin` cycles and flags a stalled slow clock. It sits between the clock divider and any processor logic that consumes slow-rate events.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth (≥2).
- `CNT_W`, 25: width of the edge-interval counter and of `half_period`.
- `TIMEOUT`, 1000: `clkin` cycles without an edge before stall is declared; must be < 2^CNT_W − 1.

- `clkin`  in  1  fast system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `slowin`  in  1  slow toggling input, asynchronous to `clkin`.
- `rise_tick`  out  1  one-cycle pulse per synchronised rising edge.
- `fall_tick`  out  1  one-cycle pulse per synchronised falling edge.
- `half_period`  out  CNT_W  `clkin` cycles between the last two edges.
- `period_valid`  out  1  `half_period` holds a real measurement.
- `stalled`  out  1  no edge seen for `TIMEOUT` cycles.

## Operation
- Reset values:
  - Synchroniser flops, `prev`, counter and all outputs are 0.
  - State is WAIT_FIRST.
- Edge detect: edge = last sync stage ≠ `prev`. `prev` follows the last sync stage every cycle.
  - Rising edge: sync = 1 → `rise_tick` = 1.
  - Falling edge: sync = 0 → `fall_tick` = 1.
  - Ticks are registered and never both high in the same cycle.
- Interval counter `cnt`:
  - Cleared to 0 on an edge.
  - Otherwise increments, saturating at 2^CNT_W − 1 with no wrap.
  - On an edge, `half_period` <= `cnt` + 1 (saturating); it holds between edges.
- States:
  - WAIT_FIRST: on edge → MEASURE. `half_period` is not updated.
  - MEASURE: on edge → LOCKED; `half_period` updated; `period_valid` <= 1.
  - LOCKED: on edge, `half_period` is updated and the state stays LOCKED.
  - Timeout, from any state when stall logic is present: `cnt` == TIMEOUT − 1 with no edge this cycle → STALLED. On that transition `stalled` <= 1 and `period_valid` <= 0.
  - STALLED: on edge → MEASURE; `stalled` <= 0. `half_period` is not updated on this edge.
- Simultaneous events:
  - An edge and the timeout condition in the same cycle: the edge wins; no stall.
- Reset mid-operation clears everything immediately, asynchronously, including an in-flight tick. After release, the first edge seen only starts measurement.
- No glitch filtering. Every synchronised level change produces a tick.

## Timing
- `slowin` changes and is captured at `clkin` edge k. The tick is high from edge k+SYNC_STAGES to edge k+SYNC_STAGES+1. With SYNC_STAGES = 2 this is 2 cycles of latency.
- `half_period`, `period_valid` and state all update on the same edge that raises the tick.
- `stalled` rises TIMEOUT cycles after the last edge's tick cycle.
- A divider toggling every N `clkin` cycles gives `half_period` = N. Minimum resolvable `half_period` is 1; consecutive toggles each produce a tick.

## Configuration
- `SLOW_MON_STALL_EN`:
  - Defined: timeout comparison, STALLED state and `stalled` output behave as above.
  - Undefined: no STALLED state, `stalled` tied to 0, `period_valid` never drops except on reset, and `TIMEOUT` is ignored. The counter still saturates.

## Test plan
- Reset, then `slowin` toggles every 11 `clkin` cycles (divider reload 10):
  - First edge: `rise_tick` only, `period_valid` = 0.
  - Second edge: `fall_tick`, `half_period` = 11, `period_valid` = 1.
  - Ticks continue to alternate.
- Latency with SYNC_STAGES = 2: `slowin` 0→1 captured at edge 100 → `rise_tick` high for exactly the cycle after edge 102.
- Stall, with macro defined and TIMEOUT = 1000: lock, then hold `slowin`.
  - `stalled` = 1 and `period_valid` = 0 exactly 1000 cycles after the last tick.
  - Next toggle: `stalled` = 0, no `half_period` update.
  - Following toggle: `period_valid` = 1.
- Edge coincident with timeout: an edge arrives on the cycle `cnt` = 999 → `stalled` stays 0 and `half_period` = 1000.
- Reset mid-operation: assert `reset` while locked at `half_period` = 11, including the cycle a tick is high.
  - All outputs go to 0 immediately.
  - After release, two edges are needed before `period_valid` = 1.
- Macro undefined, `slowin` held constant for 2^CNT_W cycles (reduce CNT_W to 8 in the bench): `stalled` stays 0 and the counter saturates at 255. Next edge sets `half_period` = 255.
